// File: rtl/scr1_acc_tcm_arb.sv
// TCM data SRAM arbiter: core dmem port vs. ACC copy engine, with ACC lock and read-data routing.
// Optional macro SCR1_ACC_ARB_STARVE_EN lets a starved ACC win contention after STARVE_MAX cycles.
module scr1_acc_tcm_arb #(
    parameter int unsigned AW         = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_core_req,
    input  logic          i_core_we,
    input  logic [AW-3:0] i_core_addr,
    input  logic [3:0]    i_core_be,
    input  logic [31:0]   i_core_wdata,
    output logic          o_core_gnt,
    output logic          o_core_rvalid,
    output logic [31:0]   o_core_rdata,
    input  logic          i_acc_req,
    input  logic          i_acc_we,
    input  logic          i_acc_lock,
    input  logic [AW-3:0] i_acc_addr,
    input  logic [31:0]   i_acc_wdata,
    output logic          o_acc_gnt,
    output logic          o_acc_rvalid,
    output logic [31:0]   o_acc_rdata,
    output logic          o_tcm_en,
    output logic [3:0]    o_tcm_we,
    output logic [AW-3:0] o_tcm_addr,
    output logic [31:0]   o_tcm_wdata,
    input  logic [31:0]   i_tcm_rdata,
    output logic          o_arb_locked
);

    localparam logic       ST_FREE   = 1'b0;
    localparam logic       ST_LOCKED = 1'b1;
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_CORE  = 2'd1;
    localparam logic [1:0] OWN_ACC   = 2'd2;

    logic        r_state;
    logic [1:0]  r_rd_owner;
    logic [31:0] r_core_rdata;
    logic [31:0] r_acc_rdata;
    logic        w_core_gnt;
    logic        w_acc_gnt;
    logic        w_acc_starved;

`ifdef SCR1_ACC_ARB_STARVE_EN
    localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);
    logic [2:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 3'd0;
        end else if (w_acc_gnt) begin
            r_starve_cnt <= 3'd0;
        end else if (i_acc_req && (r_starve_cnt != LP_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end

    assign w_acc_starved = (r_starve_cnt == LP_STARVE_MAX);
`else
    assign w_acc_starved = 1'b0;
`endif

    // Locked: core is shut out entirely so the ACC read->write pair stays atomic.
    always_comb begin
        w_core_gnt = 1'b0;
        w_acc_gnt  = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_acc_gnt = i_acc_req;
        end else if (w_acc_starved && i_acc_req) begin
            w_acc_gnt = 1'b1;
        end else if (i_core_req) begin
            w_core_gnt = 1'b1;
        end else begin
            w_acc_gnt = i_acc_req;
        end
    end

    always_comb begin
        o_tcm_en    = w_core_gnt | w_acc_gnt;
        o_tcm_we    = 4'h0;
        o_tcm_addr  = i_core_addr;
        o_tcm_wdata = i_core_wdata;
        if (w_acc_gnt) begin
            o_tcm_addr  = i_acc_addr;
            o_tcm_wdata = i_acc_wdata;
            o_tcm_we    = i_acc_we ? 4'hF : 4'h0;
        end else if (w_core_gnt && i_core_we) begin
            o_tcm_we = i_core_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FREE;
            r_rd_owner <= OWN_NONE;
        end else begin
            if (w_acc_gnt) begin
                r_state <= i_acc_lock ? ST_LOCKED : ST_FREE;
            end
            if (w_core_gnt && !i_core_we) begin
                r_rd_owner <= OWN_CORE;
            end else if (w_acc_gnt && !i_acc_we) begin
                r_rd_owner <= OWN_ACC;
            end else begin
                r_rd_owner <= OWN_NONE;
            end
        end
    end

    // Hold registers keep each master's last read word while the other one is served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rdata <= 32'h0;
            r_acc_rdata  <= 32'h0;
        end else begin
            if (r_rd_owner == OWN_CORE) begin
                r_core_rdata <= i_tcm_rdata;
            end
            if (r_rd_owner == OWN_ACC) begin
                r_acc_rdata <= i_tcm_rdata;
            end
        end
    end

    assign o_core_gnt    = w_core_gnt;
    assign o_acc_gnt     = w_acc_gnt;
    assign o_core_rvalid = (r_rd_owner == OWN_CORE);
    assign o_acc_rvalid  = (r_rd_owner == OWN_ACC);
    assign o_core_rdata  = o_core_rvalid ? i_tcm_rdata : r_core_rdata;
    assign o_acc_rdata   = o_acc_rvalid ? i_tcm_rdata : r_acc_rdata;
    assign o_arb_locked  = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_scr1_acc_tcm_arb.sv
// Self-checking bench for scr1_acc_tcm_arb: SRAM model plus per-master read-data scoreboards.
// Starvation scenario is only exercised when SCR1_ACC_ARB_STARVE_EN is defined.
module tb_scr1_acc_tcm_arb;

    localparam int unsigned AW    = 16;
    localparam int unsigned WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-3:0] core_addr = '0;
    logic [3:0]    core_be = 4'h0;
    logic [31:0]   core_wdata = 32'h0;
    logic          core_gnt, core_rvalid;
    logic [31:0]   core_rdata;
    logic          acc_req = 1'b0, acc_we = 1'b0, acc_lock = 1'b0;
    logic [AW-3:0] acc_addr = '0;
    logic [31:0]   acc_wdata = 32'h0;
    logic          acc_gnt, acc_rvalid;
    logic [31:0]   acc_rdata;
    logic          tcm_en;
    logic [3:0]    tcm_we;
    logic [AW-3:0] tcm_addr;
    logic [31:0]   tcm_wdata;
    logic [31:0]   tcm_rdata = 32'h0;
    logic          arb_locked;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] mem    [WORDS];
    logic [31:0] shadow [WORDS];
    logic [31:0] q_core [$];
    logic [31:0] q_acc  [$];
    logic [31:0] last_core = 32'h0;
    logic [31:0] last_acc  = 32'h0;

    always #5 clk = ~clk;

    scr1_acc_tcm_arb #(.AW(AW), .STARVE_MAX(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_core_req   (core_req),
        .i_core_we    (core_we),
        .i_core_addr  (core_addr),
        .i_core_be    (core_be),
        .i_core_wdata (core_wdata),
        .o_core_gnt   (core_gnt),
        .o_core_rvalid(core_rvalid),
        .o_core_rdata (core_rdata),
        .i_acc_req    (acc_req),
        .i_acc_we     (acc_we),
        .i_acc_lock   (acc_lock),
        .i_acc_addr   (acc_addr),
        .i_acc_wdata  (acc_wdata),
        .o_acc_gnt    (acc_gnt),
        .o_acc_rvalid (acc_rvalid),
        .o_acc_rdata  (acc_rdata),
        .o_tcm_en     (tcm_en),
        .o_tcm_we     (tcm_we),
        .o_tcm_addr   (tcm_addr),
        .o_tcm_wdata  (tcm_wdata),
        .i_tcm_rdata  (tcm_rdata),
        .o_arb_locked (arb_locked)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Single-port SRAM model driven by the DUT's strobes.
    always @(posedge clk) begin
        if (tcm_en) begin
            if (tcm_we == 4'h0) begin
                tcm_rdata <= mem[tcm_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (tcm_we[b]) mem[tcm_addr][8*b +: 8] <= tcm_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read-data scoreboard; also checks the idle master's rdata holds its last value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_rvalid) begin
                if (q_core.size() == 0) begin
                    check("core_spurious_rvalid", 32'(core_rvalid), 32'h0);
                end else begin
                    last_core = q_core.pop_front();
                    check("core_rdata", core_rdata, last_core);
                end
            end else begin
                check("core_rdata_hold", core_rdata, last_core);
            end
            if (acc_rvalid) begin
                if (q_acc.size() == 0) begin
                    check("acc_spurious_rvalid", 32'(acc_rvalid), 32'h0);
                end else begin
                    last_acc = q_acc.pop_front();
                    check("acc_rdata", acc_rdata, last_acc);
                end
            end else begin
                check("acc_rdata_hold", acc_rdata, last_acc);
            end
        end
    end

    // Inputs are already set; check grants mid-cycle, update the bench's model, advance.
    task automatic cyc(input string tag, input logic exp_cg, input logic exp_ag);
        @(negedge clk);
        check({tag, "_core_gnt"}, 32'(core_gnt), 32'(exp_cg));
        check({tag, "_acc_gnt"}, 32'(acc_gnt), 32'(exp_ag));
        check({tag, "_tcm_en"}, 32'(tcm_en), 32'(exp_cg | exp_ag));
        if (exp_cg) begin
            check({tag, "_tcm_addr"}, 32'(tcm_addr), 32'(core_addr));
            check({tag, "_tcm_we"}, 32'(tcm_we), core_we ? 32'(core_be) : 32'h0);
            if (core_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (core_be[b]) shadow[core_addr][8*b +: 8] = core_wdata[8*b +: 8];
                end
            end else begin
                q_core.push_back(shadow[core_addr]);
            end
        end else if (exp_ag) begin
            check({tag, "_tcm_addr"}, 32'(tcm_addr), 32'(acc_addr));
            check({tag, "_tcm_we"}, 32'(tcm_we), acc_we ? 32'hF : 32'h0);
            if (acc_we) begin
                check({tag, "_tcm_wdata"}, tcm_wdata, acc_wdata);
                shadow[acc_addr] = acc_wdata;
            end else begin
                q_acc.push_back(shadow[acc_addr]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic we, input int addr, input logic [3:0] be,
                            input logic [31:0] wd);
        core_req = req; core_we = we; core_addr = AW'(addr) >> 0; core_be = be; core_wdata = wd;
    endtask

    task automatic set_acc(input logic req, input logic we, input logic lock, input int addr,
                           input logic [31:0] wd);
        acc_req = req; acc_we = we; acc_lock = lock; acc_addr = (AW-2)'(addr); acc_wdata = wd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_gnt"}, 32'(core_gnt), 32'h0);
        check({tag, "_acc_gnt"}, 32'(acc_gnt), 32'h0);
        check({tag, "_core_rvalid"}, 32'(core_rvalid), 32'h0);
        check({tag, "_acc_rvalid"}, 32'(acc_rvalid), 32'h0);
        check({tag, "_core_rdata"}, core_rdata, 32'h0);
        check({tag, "_acc_rdata"}, acc_rdata, 32'h0);
        check({tag, "_tcm_en"}, 32'(tcm_en), 32'h0);
        check({tag, "_tcm_we"}, 32'(tcm_we), 32'h0);
        check({tag, "_locked"}, 32'(arb_locked), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i]    = (i * 32'h9E3779B1) + 32'h1234_0001;
            shadow[i] = (i * 32'h9E3779B1) + 32'h1234_0001;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Core read alone.
        set_core(1, 0, 'h10, 4'h0, 0);
        cyc("core_rd", 1, 0);
        set_core(0, 0, 0, 4'h0, 0);
        cyc("core_rd_idle", 0, 0);

        // Contention in FREE: core first, ACC once core drops.
        set_core(1, 0, 'h11, 4'h0, 0);
        set_acc(1, 0, 0, 'h30, 0);
        cyc("cont_both", 1, 0);
        set_core(0, 0, 0, 4'h0, 0);
        cyc("cont_acc", 0, 1);
        set_acc(0, 0, 0, 0, 0);
        cyc("cont_idle", 0, 0);

        // Locked copy: read 0x20 with lock, an idle locked cycle, then write 0x40 and unlock.
        set_acc(1, 0, 1, 'h20, 0);
        cyc("lk_rd", 0, 1);
        check("lk_locked_a", 32'(arb_locked), 32'h1);
        set_acc(0, 0, 0, 0, 0);
        set_core(1, 0, 'h40, 4'h0, 0);
        cyc("lk_gap", 0, 0);
        check("lk_locked_b", 32'(arb_locked), 32'h1);
        set_acc(1, 1, 0, 'h40, 32'hC0FF_EE01);
        cyc("lk_wr", 0, 1);
        check("lk_unlocked", 32'(arb_locked), 32'h0);
        set_acc(0, 0, 0, 0, 0);
        cyc("lk_core_after", 1, 0);
        set_core(0, 0, 0, 4'h0, 0);
        cyc("lk_idle", 0, 0);

        // Back-to-back mixed traffic, including a partial core write during ACC rvalid.
        set_core(1, 0, 'h05, 4'h0, 0);
        cyc("b2b_core_rd", 1, 0);
        set_core(0, 0, 0, 4'h0, 0);
        set_acc(1, 0, 0, 'h06, 0);
        cyc("b2b_acc_rd", 0, 1);
        set_acc(0, 0, 0, 0, 0);
        set_core(1, 1, 'h05, 4'b0011, 32'hDEAD_BEEF);
        cyc("b2b_core_wr", 1, 0);
        set_core(0, 0, 0, 4'h0, 0);
        set_acc(1, 0, 0, 'h05, 0);
        cyc("b2b_acc_rd2", 0, 1);
        set_acc(0, 0, 0, 0, 0);
        cyc("b2b_idle", 0, 0);

`ifdef SCR1_ACC_ARB_STARVE_EN
        // Both held: core wins four cycles, ACC wins the fifth, then core again.
        set_core(1, 0, 'h07, 4'h0, 0);
        set_acc(1, 0, 0, 'h08, 0);
        for (int k = 0; k < 4; k++) cyc("starve_core", 1, 0);
        cyc("starve_acc", 0, 1);
        cyc("starve_core_after", 1, 0);
        set_core(0, 0, 0, 4'h0, 0);
        set_acc(0, 0, 0, 0, 0);
        cyc("starve_idle", 0, 0);
`endif

        // Reset while locked with an ACC read in flight: aborted, no rvalid afterwards.
        set_acc(1, 0, 1, 'h21, 0);
        cyc("rst_lk_rd", 0, 1);
        set_acc(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        q_acc.delete();
        last_core = 32'h0;
        last_acc  = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_after_a", 0, 0);
        cyc("rst_after_b", 0, 0);

        check("q_core_empty", q_core.size(), 0);
        check("q_acc_empty", q_acc.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
